// File: rtl/updown_step_ctrl.sv
// updown_step_ctrl: conditions the board switches/buttons and sequences
// Step/Dir for the up/down counter, with optional auto-reverse at the limits.
module updown_step_ctrl #(
  parameter int WIDTH     = 4,
  parameter int PRESCALE  = 1000,
  parameter int DB_CYCLES = 20
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             Sw_Mode,
  input  logic             Sw_Bounce,
  input  logic             Btn_Run,
  input  logic             Btn_Step,
  input  logic [WIDTH-1:0] Count,
  output logic             Step,
  output logic             Dir,
  output logic             Running
);

  // state | meaning
  // PAUSE | idle; a step button press issues one Step
  // RUN   | prescaler counting; a Step every PRESCALE cycles
  localparam logic [0:0] ST_PAUSE = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  localparam int IN_MODE   = 0;
  localparam int IN_BOUNCE = 1;
  localparam int IN_RUN    = 2;
  localparam int IN_STEP   = 3;

  logic [3:0]          w_raw;
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [3:0]          r_db;
  logic [3:0]          r_db_prev;
  logic [3:0][DW-1:0]  r_db_cnt;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [PW-1:0]       r_presc;
  logic                r_step;
  logic                r_dir;

  logic                w_run_p;
  logic                w_step_p;
  logic                w_bounce_rise;
  logic                w_tick;
  logic                w_gen;

  assign w_raw = {Btn_Step, Btn_Run, Sw_Bounce, Sw_Mode};

  // The debounced value only flips after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_run_p       = r_db[IN_RUN]    & ~r_db_prev[IN_RUN];
  assign w_step_p      = r_db[IN_STEP]   & ~r_db_prev[IN_STEP];
  assign w_bounce_rise = r_db[IN_BOUNCE] & ~r_db_prev[IN_BOUNCE];
  assign w_tick        = (r_state == ST_RUN) && (r_presc == PS_LAST);

  // run_p has priority: it swallows a same-cycle step_p or tick.
  always_comb begin
    w_state_nxt = r_state;
    w_gen       = 1'b0;
    case (r_state)
      ST_PAUSE: begin
        if (w_run_p)       w_state_nxt = ST_RUN;
        else if (w_step_p) w_gen       = 1'b1;
      end
      default: begin
        if (w_run_p)     w_state_nxt = ST_PAUSE;
        else if (w_tick) w_gen       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_state <= ST_PAUSE;
      r_presc <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_gen;
      if ((r_state == ST_PAUSE) && w_run_p) begin
        r_presc <= '0;
      end else if ((r_state == ST_RUN) && !w_run_p) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
      // Count is stable in the generation cycle, so the reversal is decided here.
      if (!r_db[IN_BOUNCE] || w_bounce_rise) begin
        r_dir <= r_db[IN_MODE];
      end else if (w_gen) begin
        if (!r_dir && (Count == '1))     r_dir <= 1'b1;
        else if (r_dir && (Count == '0)) r_dir <= 1'b0;
      end
    end
  end

  assign Step    = r_step;
  assign Dir     = r_dir;
  assign Running = (r_state == ST_RUN);

endmodule

// File: tb/tb_updown_step_ctrl.sv
// tb_updown_step_ctrl: directed scenarios plus randomized inputs, checked against
// a rule-level reference model and a behavioural 4-bit counter.
module tb_updown_step_ctrl;

  localparam int W  = 4;
  localparam int PS = 4;
  localparam int DB = 3;

  logic         Clk = 1'b0;
  logic         RST = 1'b0;
  logic         sw_mode = 1'b0;
  logic         sw_bounce = 1'b0;
  logic         btn_run = 1'b0;
  logic         btn_step = 1'b0;
  logic [W-1:0] cnt = '0;
  logic         cnt_ld = 1'b0;
  logic [W-1:0] cnt_ld_v = '0;
  logic         Step;
  logic         Dir;
  logic         Running;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic cmp_en = 1'b0;

  updown_step_ctrl #(.WIDTH(W), .PRESCALE(PS), .DB_CYCLES(DB)) u_dut (
    .Clk      (Clk),
    .RST      (RST),
    .Sw_Mode  (sw_mode),
    .Sw_Bounce(sw_bounce),
    .Btn_Run  (btn_run),
    .Btn_Step (btn_step),
    .Count    (cnt),
    .Step     (Step),
    .Dir      (Dir),
    .Running  (Running)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // The counter datapath the controller drives.
  always @(posedge Clk) begin
    if (cnt_ld)    cnt <= cnt_ld_v;
    else if (Step) cnt <= Dir ? cnt - 4'd1 : cnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: synchronised samples kept in a sliding window; a debounced
  // value flips once the whole window disagrees with it.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_db_last = '0, m_raw, m_dbn;
  logic [3:0] m_hist[$];
  bit         m_running = 0, m_step = 0, m_dir = 0, m_gen, m_run_p, m_step_p, m_all;
  int         m_run_cycles = 0;

  always @(posedge Clk or negedge RST) begin
    if (!RST) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_db_last = '0;
      m_hist.delete();
      m_running = 0; m_step = 0; m_dir = 0; m_run_cycles = 0;
    end else begin
      m_raw = {btn_step, btn_run, sw_bounce, sw_mode};
      m_hist.push_back(m_s2);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      m_dbn = m_db;
      if (m_hist.size() == DB) begin
        for (int i = 0; i < 4; i++) begin
          m_all = 1;
          foreach (m_hist[j]) if (m_hist[j][i] == m_db[i]) m_all = 0;
          if (m_all) m_dbn[i] = ~m_db[i];
        end
      end
      m_run_p  = m_db[2] & ~m_db_last[2];
      m_step_p = m_db[3] & ~m_db_last[3];
      m_gen    = 0;
      if (m_running) begin
        if (m_run_p) m_running = 0;
        else begin
          m_gen = ((m_run_cycles % PS) == PS - 1);
          m_run_cycles++;
        end
      end else if (m_run_p) begin
        m_running = 1;
        m_run_cycles = 0;
      end else begin
        m_gen = m_step_p;
      end
      if (!m_db[1] || !m_db_last[1]) m_dir = m_db[0];
      else if (m_gen && ((!m_dir && cnt == 4'hF) || (m_dir && cnt == 4'h0))) m_dir = ~m_dir;
      m_step    = m_gen;
      m_db_last = m_db;
      m_db      = m_dbn;
      m_s2      = m_s1;
      m_s1      = m_raw;
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_step", 32'(Step), 32'(m_step));
      chk("model_dir", 32'(Dir), 32'(m_dir));
      chk("model_running", 32'(Running), 32'(m_running));
    end
  end

  task automatic wait_step(input string tag, output int at);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Step && n < 40);
    chk(tag, 32'(Step), 32'd1);
    at = cyc;
  endtask

  task automatic next_count(input string tag, output logic [W-1:0] c);
    int at;
    wait_step(tag, at);
    @(negedge Clk);
    c = cnt;
  endtask

  task automatic press_run(input int hold);
    btn_run = 1'b1;
    repeat (hold) @(negedge Clk);
    btn_run = 1'b0;
  endtask

  task automatic load_count(input logic [W-1:0] v);
    @(negedge Clk);
    cnt_ld = 1'b1; cnt_ld_v = v;
    @(negedge Clk);
    cnt_ld = 1'b0;
  endtask

  initial begin
    int a, b, n;
    logic [W-1:0] c, e;
    logic d, dir_seen;

    repeat (3) @(negedge Clk);
    cmp_en = 1'b1;
    chk("rst_step", 32'(Step), 32'd0);
    chk("rst_dir", 32'(Dir), 32'd0);
    chk("rst_running", 32'(Running), 32'd0);
    RST = 1'b1;
    repeat (4) @(negedge Clk);

    // Reset then run: Running after 2 sync + 3 debounce + 1 edge cycles.
    sw_mode = 1'b1;
    repeat (8) @(negedge Clk);
    btn_run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (k == 4) btn_run = 1'b0;
      if (k == 5) chk("run_early", 32'(Running), 32'd0);
      if (k == 6) chk("run_latency", 32'(Running), 32'd1);
      if (k == 9) chk("first_step_early", 32'(Step), 32'd0);
      if (k == 10) chk("first_step", 32'(Step), 32'd1);
    end
    a = cyc;
    wait_step("period_step", b);
    chk("step_period", 32'(b - a), 32'(PS));

    // Asynchronous reset with a Step pending on the next edge.
    repeat (3) @(negedge Clk);
    #2 RST = 1'b0;
    #1;
    chk("arst_step", 32'(Step), 32'd0);
    chk("arst_dir", 32'(Dir), 32'd0);
    chk("arst_running", 32'(Running), 32'd0);
    @(negedge Clk);
    chk("arst_pending", 32'(Step), 32'd0);
    sw_mode = 1'b0;
    #2 RST = 1'b1;
    repeat (6) @(negedge Clk);

    // Two-cycle glitch is filtered; a ten-cycle hold toggles exactly once.
    btn_run = 1'b1;
    repeat (2) @(negedge Clk);
    btn_run = 1'b0;
    repeat (12) @(negedge Clk);
    chk("glitch_running", 32'(Running), 32'd0);
    btn_run = 1'b1;
    repeat (10) @(negedge Clk);
    btn_run = 1'b0;
    repeat (10) @(negedge Clk);
    chk("hold_running", 32'(Running), 32'd1);
    press_run(4);
    repeat (10) @(negedge Clk);
    chk("pause_running", 32'(Running), 32'd0);

    // Single step while paused carries Dir = Sw_Mode.
    sw_mode = 1'b1;
    repeat (8) @(negedge Clk);
    btn_step = 1'b1;
    n = 0; dir_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (k == 4) btn_step = 1'b0;
      if (Step) begin n++; dir_seen = Dir; end
    end
    chk("single_step_count", 32'(n), 32'd1);
    chk("single_step_dir", 32'(dir_seen), 32'd1);

    // Step button while running adds nothing to the periodic stream.
    press_run(4);
    repeat (12) @(negedge Clk);
    btn_step = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (k == 4) btn_step = 1'b0;
      if (Step) n++;
    end
    chk("run_step_count", 32'(n), 32'(40 / PS));
    press_run(4);
    repeat (10) @(negedge Clk);

    // Wrap mode from Count=0.
    sw_mode = 1'b0;
    repeat (8) @(negedge Clk);
    load_count(4'd0);
    press_run(4);
    for (int i = 0; i < 17; i++) begin
      next_count("wrap_step", c);
      chk("wrap_count", 32'(c), 32'((i + 1) % 16));
    end
    sw_mode = 1'b1;
    repeat (8) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      wait_step("down_step", a);
      chk("down_dir", 32'(Dir), 32'd1);
    end
    press_run(4);
    repeat (10) @(negedge Clk);

    // Bounce mode from Count=13 heading up.
    sw_mode = 1'b0;
    repeat (8) @(negedge Clk);
    sw_bounce = 1'b1;
    repeat (8) @(negedge Clk);
    load_count(4'd13);
    press_run(4);
    e = 4'd13; d = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (!d && e == 4'd15) d = 1'b1;
      else if (d && e == 4'd0) d = 1'b0;
      e = d ? e - 4'd1 : e + 4'd1;
      next_count("bounce_step", c);
      chk("bounce_count", 32'(c), 32'(e));
    end
    press_run(4);
    repeat (10) @(negedge Clk);
    sw_bounce = 1'b0;
    repeat (8) @(negedge Clk);

    // Run and step debounce on the same cycle: run wins.
    btn_run = 1'b1; btn_step = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (k == 4) begin btn_run = 1'b0; btn_step = 1'b0; end
      if (k == 6) chk("sim_running", 32'(Running), 32'd1);
      if (k == 7) chk("sim_no_step", 32'(Step), 32'd0);
      if (k == 10) chk("sim_first_step", 32'(Step), 32'd1);
    end

    // Randomized inputs against the model, with occasional resets.
    for (int it = 0; it < 150; it++) begin
      @(negedge Clk);
      if ($urandom_range(0, 39) == 0) begin
        #2 RST = 1'b0;
        @(negedge Clk);
        #2 RST = 1'b1;
      end
      sw_mode   = ($urandom_range(0, 1) == 1);
      sw_bounce = ($urandom_range(0, 3) == 0);
      btn_run   = ($urandom_range(0, 5) == 0);
      btn_step  = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 10)) @(negedge Clk);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
